// File: rtl/bob_pkg.sv
// Shared branch order buffer constants and entry layout, also used by the predictor and retire logic.
package bob_pkg;

    localparam int BOB_DEPTH = 16;
    localparam int BRPC_W    = 64;
    localparam int BHR_W     = 12;
    localparam int BHT_W     = 10;
    localparam int ENTRY_W   = BRPC_W + BHR_W + BHT_W + 2;

    // Bit offsets of each field inside a packed entry (LSB first)
    localparam int CHBRDIR_OFS = 0;
    localparam int CHWE_OFS    = 1;
    localparam int BHT_OFS     = 2;
    localparam int BHR_OFS     = BHT_OFS + BHT_W;
    localparam int BRPC_OFS    = BHR_OFS + BHR_W;

    typedef struct packed {
        logic [BRPC_W-1:0] brpc;
        logic [BHR_W-1:0]  bhr;
        logic [BHT_W-1:0]  bht;
        logic              chwe;
        logic              chbrdir;
    } bob_entry_t;

endpackage

// File: rtl/bob_ram.sv
// Entry storage: flop array with one write port and one asynchronous read port; not reset.
module bob_ram
    import bob_pkg::*;
#(
    parameter int DEPTH = BOB_DEPTH,
    parameter int PTR_W = 4
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  bob_entry_t       wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output bob_entry_t       rdata_o
);

    bob_entry_t mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bob.sv
// Branch order buffer: circular FIFO of in-flight branch predictor state, oldest entry exposed at the head.
module bob
    import bob_pkg::*;
#(
    parameter int DEPTH = BOB_DEPTH,
    parameter int PTR_W = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               alloc_vld_i,
    input  logic [BRPC_W-1:0]  alloc_brpc_i,
    input  logic [BHR_W-1:0]   alloc_bhr_i,
    input  logic [BHT_W-1:0]   alloc_bht_i,
    input  logic               alloc_chwe_i,
    input  logic               alloc_chbrdir_i,
    input  logic               retire_vld_i,
    input  logic               pipctl_flush_rt_i,
    output logic               bob_full_o,
    output logic [PTR_W-1:0]   bob_alloc_idx_o,
    output logic               bob_valid_o,
    output logic [BRPC_W-1:0]  bob_brpc_o,
    output logic [BHR_W-1:0]   bob_bhr_o,
    output logic [BHT_W-1:0]   bob_bht_o,
    output logic               bob_chwe_o,
    output logic               bob_chbrdir_o,
    output logic [PTR_W:0]     bob_count_o
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             alloc_acc, retire_acc;
    bob_entry_t       wr_entry, rd_entry, head_entry;

    always_comb begin
        bob_full_o  = (count_q == DEPTH_C);
        bob_valid_o = (count_q != '0);
        alloc_acc   = alloc_vld_i & ~bob_full_o & ~pipctl_flush_rt_i;
        retire_acc  = retire_vld_i & bob_valid_o & ~pipctl_flush_rt_i;

        wr_entry = '{brpc: alloc_brpc_i, bhr: alloc_bhr_i, bht: alloc_bht_i,
                     chwe: alloc_chwe_i, chbrdir: alloc_chbrdir_i};

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pipctl_flush_rt_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_acc)  tail_d = tail_q + 1'b1;
            if (retire_acc) head_d = head_q + 1'b1;
            unique case ({alloc_acc, retire_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    bob_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
        .clock   (clock),
        .we_i    (alloc_acc),
        .waddr_i (tail_q),
        .wdata_i (wr_entry),
        .raddr_i (head_q),
        .rdata_o (rd_entry)
    );

    // Storage is never reset, so stale contents are hidden whenever the buffer is empty
    assign head_entry      = bob_valid_o ? rd_entry : '0;
    assign bob_brpc_o      = head_entry.brpc;
    assign bob_bhr_o       = head_entry.bhr;
    assign bob_bht_o       = head_entry.bht;
    assign bob_chwe_o      = head_entry.chwe;
    assign bob_chbrdir_o   = head_entry.chbrdir;
    assign bob_alloc_idx_o = tail_q;
    assign bob_count_o     = count_q;

endmodule

// File: tb/tb_bob.sv
// Scoreboard bench for bob: entries queued on accepted allocate, compared at the head as they retire.
module tb_bob;
    import bob_pkg::*;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              alloc_vld_i, alloc_chwe_i, alloc_chbrdir_i;
    logic [BRPC_W-1:0] alloc_brpc_i;
    logic [BHR_W-1:0]  alloc_bhr_i;
    logic [BHT_W-1:0]  alloc_bht_i;
    logic              retire_vld_i, pipctl_flush_rt_i;
    logic              bob_full_o, bob_valid_o, bob_chwe_o, bob_chbrdir_o;
    logic [PTR_W-1:0]  bob_alloc_idx_o;
    logic [BRPC_W-1:0] bob_brpc_o;
    logic [BHR_W-1:0]  bob_bhr_o;
    logic [BHT_W-1:0]  bob_bht_o;
    logic [PTR_W:0]    bob_count_o;

    int checks = 0;
    int errors = 0;

    bob_entry_t       sb[$];
    logic [PTR_W-1:0] exp_tail;

    bob #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .alloc_vld_i(alloc_vld_i), .alloc_brpc_i(alloc_brpc_i), .alloc_bhr_i(alloc_bhr_i),
        .alloc_bht_i(alloc_bht_i), .alloc_chwe_i(alloc_chwe_i), .alloc_chbrdir_i(alloc_chbrdir_i),
        .retire_vld_i(retire_vld_i), .pipctl_flush_rt_i(pipctl_flush_rt_i),
        .bob_full_o(bob_full_o), .bob_alloc_idx_o(bob_alloc_idx_o), .bob_valid_o(bob_valid_o),
        .bob_brpc_o(bob_brpc_o), .bob_bhr_o(bob_bhr_o), .bob_bht_o(bob_bht_o),
        .bob_chwe_o(bob_chwe_o), .bob_chbrdir_o(bob_chbrdir_o), .bob_count_o(bob_count_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic bob_entry_t rand_entry();
        bob_entry_t e;
        e.brpc    = {$urandom, $urandom};
        e.bhr     = BHR_W'($urandom);
        e.bht     = BHT_W'($urandom);
        e.chwe    = 1'($urandom);
        e.chbrdir = 1'($urandom);
        return e;
    endfunction

    function automatic bob_entry_t head_obs();
        return '{brpc: bob_brpc_o, bhr: bob_bhr_o, bht: bob_bht_o,
                 chwe: bob_chwe_o, chbrdir: bob_chbrdir_o};
    endfunction

    task automatic set_in(input logic a, input bob_entry_t e, input logic r, input logic f);
        alloc_vld_i       = a;
        alloc_brpc_i      = e.brpc;
        alloc_bhr_i       = e.bhr;
        alloc_bht_i       = e.bht;
        alloc_chwe_i      = e.chwe;
        alloc_chbrdir_i   = e.chbrdir;
        retire_vld_i      = r;
        pipctl_flush_rt_i = f;
    endtask

    // Advance one edge and update the reference FIFO from the inputs currently applied
    task automatic step();
        bob_entry_t e;
        bit acc_a, acc_r;
        e = '{brpc: alloc_brpc_i, bhr: alloc_bhr_i, bht: alloc_bht_i,
              chwe: alloc_chwe_i, chbrdir: alloc_chbrdir_i};
        acc_a = alloc_vld_i && sb.size() < DEPTH && !pipctl_flush_rt_i;
        acc_r = retire_vld_i && sb.size() > 0 && !pipctl_flush_rt_i;
        @(posedge clock);
        if (pipctl_flush_rt_i) begin
            sb.delete();
            exp_tail = '0;
        end else begin
            if (acc_r) void'(sb.pop_front());
            if (acc_a) begin
                sb.push_back(e);
                exp_tail = exp_tail + 1'b1;
            end
        end
        #1;
        set_in(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        set_in(1'b0, '0, 1'b0, 1'b0);
        reset_n = 1'b0;
        exp_tail = '0;
        #22;
        checks++; if (bob_count_o !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bob_count_o); end
        checks++; if (bob_valid_o !== 1'b0 || bob_full_o !== 1'b0) begin errors++; $display("FAIL reset_flags valid=%b full=%b exp=0/0", bob_valid_o, bob_full_o); end
        checks++; if (bob_alloc_idx_o !== '0 || head_obs() !== '0) begin errors++; $display("FAIL reset_head idx=%0d head=%h exp=0", bob_alloc_idx_o, head_obs()); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_alloc();
        bob_entry_t e = '{brpc: 64'h1000, bhr: 12'hABC, bht: 10'h155, chwe: 1'b1, chbrdir: 1'b0};
        set_in(1'b1, e, 1'b0, 1'b0);
        step();
        checks++; if (bob_valid_o !== 1'b1 || bob_count_o !== 5'd1) begin errors++; $display("FAIL single_state valid=%b count=%0d exp=1/1", bob_valid_o, bob_count_o); end
        checks++; if (head_obs() !== e) begin errors++; $display("FAIL single_head got=%h exp=%h", head_obs(), e); end
        checks++; if (bob_alloc_idx_o !== 4'd1) begin errors++; $display("FAIL single_idx got=%0d exp=1", bob_alloc_idx_o); end
        set_in(1'b0, '0, 1'b0, 1'b1);
        step();
    endtask

    task automatic test_drain(input string name);
        bob_entry_t exp;
        for (int i = 0; i < DEPTH + 2 && sb.size() > 0; i++) begin
            exp = sb[0];
            checks++; if (head_obs() !== exp || bob_valid_o !== 1'b1) begin errors++; $display("FAIL %s_head got=%h exp=%h", name, head_obs(), exp); end
            set_in(1'b0, '0, 1'b1, 1'b0);
            step();
        end
        checks++; if (sb.size() != 0 || bob_count_o !== '0 || bob_valid_o !== 1'b0) begin errors++; $display("FAIL %s_empty count=%0d exp=0", name, bob_count_o); end
    endtask

    task automatic test_fill_and_full();
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (bob_full_o !== 1'b0) begin errors++; $display("FAIL fill_notfull i=%0d full=%b exp=0", i, bob_full_o); end
            set_in(1'b1, rand_entry(), 1'b0, 1'b0);
            step();
        end
        checks++; if (bob_full_o !== 1'b1 || bob_count_o !== 5'd16) begin errors++; $display("FAIL fill_full full=%b count=%0d exp=1/16", bob_full_o, bob_count_o); end
        set_in(1'b1, rand_entry(), 1'b0, 1'b0);
        step();
        checks++; if (bob_count_o !== 5'd16 || bob_alloc_idx_o !== 4'd0) begin errors++; $display("FAIL overflow count=%0d idx=%0d exp=16/0", bob_count_o, bob_alloc_idx_o); end
        // Full: the same-cycle allocate is still rejected, only the retire takes effect
        set_in(1'b1, rand_entry(), 1'b1, 1'b0);
        step();
        checks++; if (bob_count_o !== 5'd15 || bob_alloc_idx_o !== exp_tail) begin errors++; $display("FAIL full_ar count=%0d idx=%0d exp=15/%0d", bob_count_o, bob_alloc_idx_o, exp_tail); end
        checks++; if (head_obs() !== sb[0]) begin errors++; $display("FAIL full_ar_head got=%h exp=%h", head_obs(), sb[0]); end
        test_drain("full_drain");
    endtask

    task automatic test_back_to_back();
        set_in(1'b0, '0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, rand_entry(), 1'b0, 1'b0);
            step();
        end
        set_in(1'b1, rand_entry(), 1'b1, 1'b0);
        step();
        checks++; if (bob_count_o !== 5'd3 || bob_alloc_idx_o !== 4'd4) begin errors++; $display("FAIL b2b count=%0d idx=%0d exp=3/4", bob_count_o, bob_alloc_idx_o); end
        checks++; if (head_obs() !== sb[0]) begin errors++; $display("FAIL b2b_head got=%h exp=%h", head_obs(), sb[0]); end
        for (int i = 0; i < 40; i++) begin
            checks++; if (head_obs() !== sb[0] || bob_count_o !== 5'd3) begin errors++; $display("FAIL wrap_head i=%0d got=%h exp=%h count=%0d", i, head_obs(), sb[0], bob_count_o); end
            set_in(1'b1, rand_entry(), 1'b1, 1'b0);
            step();
        end
        checks++; if (bob_alloc_idx_o !== exp_tail) begin errors++; $display("FAIL wrap_idx got=%0d exp=%0d", bob_alloc_idx_o, exp_tail); end
        test_drain("wrap_drain");
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, rand_entry(), 1'b0, 1'b0);
            step();
        end
        set_in(1'b1, rand_entry(), 1'b1, 1'b1);
        #1;
        checks++; if (head_obs() !== sb[0] || bob_valid_o !== 1'b1 || bob_count_o !== 5'd5) begin errors++; $display("FAIL flush_sameclk got=%h exp=%h", head_obs(), sb[0]); end
        step();
        checks++; if (bob_count_o !== '0 || bob_valid_o !== 1'b0 || bob_alloc_idx_o !== '0) begin errors++; $display("FAIL flush_after count=%0d valid=%b idx=%0d exp=0", bob_count_o, bob_valid_o, bob_alloc_idx_o); end
        checks++; if (head_obs() !== '0) begin errors++; $display("FAIL flush_head got=%h exp=0", head_obs()); end
    endtask

    task automatic test_empty_retire();
        set_in(1'b0, '0, 1'b1, 1'b0);
        step();
        checks++; if (bob_count_o !== '0 || bob_alloc_idx_o !== '0 || bob_valid_o !== 1'b0) begin errors++; $display("FAIL empty_retire count=%0d idx=%0d exp=0/0", bob_count_o, bob_alloc_idx_o); end
        set_in(1'b1, rand_entry(), 1'b1, 1'b0);
        step();
        checks++; if (bob_count_o !== 5'd1 || head_obs() !== sb[0]) begin errors++; $display("FAIL empty_ar count=%0d head=%h exp=1/%h", bob_count_o, head_obs(), sb[0]); end
    endtask

    task automatic test_reset_mid();
        bob_entry_t e;
        while (sb.size() < 7) begin
            set_in(1'b1, rand_entry(), 1'b0, 1'b0);
            step();
        end
        checks++; if (bob_count_o !== 5'd7) begin errors++; $display("FAIL rstmid_pre count=%0d exp=7", bob_count_o); end
        #2 reset_n = 1'b0;
        sb.delete();
        exp_tail = '0;
        #1;
        checks++; if (bob_count_o !== '0 || bob_valid_o !== 1'b0 || bob_alloc_idx_o !== '0 || head_obs() !== '0) begin errors++; $display("FAIL rstmid_async count=%0d valid=%b idx=%0d head=%h exp=0", bob_count_o, bob_valid_o, bob_alloc_idx_o, head_obs()); end
        #10 reset_n = 1'b1;
        @(negedge clock);
        e = rand_entry();
        set_in(1'b1, e, 1'b0, 1'b0);
        step();
        checks++; if (bob_count_o !== 5'd1 || bob_alloc_idx_o !== 4'd1 || head_obs() !== e) begin errors++; $display("FAIL rstmid_realloc count=%0d idx=%0d head=%h exp=1/1/%h", bob_count_o, bob_alloc_idx_o, head_obs(), e); end
    endtask

    initial begin
        test_reset();
        test_single_alloc();
        test_fill_and_full();
        test_back_to_back();
        test_flush();
        test_empty_retire();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
